// File: rtl/ula_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ula_wb_buffer
// Purpose  : Result FIFO between the ULAS execute unit and the register-file
//            writeback port. Buffers r1/UF/rd/we/cmp per entry, drains under
//            a valid/ready handshake, owns the architectural compare flag
//            (updated when a compare entry is written back) and offers a
//            combinational forwarding lookup over not-yet-written results.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready, in_r1, in_uf, in_rd, in_we, in_cmp  - push side
//            out_valid/out_ready, out_data, out_rd, out_we           - drain side
//            flag_q                                                  - compare flag
//            fwd_rs -> fwd_hit, fwd_data                             - forwarding
// Revision : 1.0  initial release
// ============================================================================
module ula_wb_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_r1,
    input  logic        in_uf,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    input  logic        in_cmp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        flag_q,
    input  logic [4:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    // Entry storage, indexed by physical slot
    logic [31:0]      r_data [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_uf;
    logic [DEPTH-1:0] r_cmp;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_flag;

    logic             w_push;
    logic             w_pop;

    // Readiness depends only on occupancy so no combinational path exists
    // from out_ready to in_ready; a full buffer stalls even while draining.
    assign in_ready  = (r_count != c_depth);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign out_data  = r_data[r_rd_ptr];
    assign out_rd    = r_rd[r_rd_ptr];
    assign out_we    = r_we[r_rd_ptr];
    assign flag_q    = r_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_rd[i]   <= '0;
            end
            r_we     <= '0;
            r_uf     <= '0;
            r_cmp    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_flag   <= 1'b0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= in_r1;
                r_rd[r_wr_ptr]   <= in_rd;
                // Register 0 is hardwired: drop its write-enable at capture so
                // neither writeback nor forwarding ever sees it.
                r_we[r_wr_ptr]   <= in_we & (in_rd != 5'd0);
                r_uf[r_wr_ptr]   <= in_uf;
                r_cmp[r_wr_ptr]  <= in_cmp;
                r_wr_ptr         <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                // The compare flag becomes architectural only at writeback
                if (r_cmp[r_rd_ptr]) begin
                    r_flag <= r_uf[r_rd_ptr];
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Map each age (0 = oldest/head) to its physical slot and validity, so
    // the forwarding scan can walk entries in acceptance order.
    logic [AW-1:0]    w_age_slot  [DEPTH];
    logic [DEPTH-1:0] w_age_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        assign w_age_slot[g]  = r_rd_ptr + AW'(g);
        assign w_age_valid[g] = ((AW+1)'(g) < r_count);
    end

    // Scan oldest to newest; a later match overrides an earlier one, so the
    // result is the newest matching entry.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_age_valid[k] && r_we[w_age_slot[k]] &&
                (r_rd[w_age_slot[k]] == fwd_rs) && (fwd_rs != 5'd0)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[w_age_slot[k]];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ula_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_wb_buffer
// Purpose  : Self-checking bench for ula_wb_buffer. A queue-based model of the
//            buffer is advanced on every rising edge from the applied inputs;
//            a compare process checks all outputs against it on each falling
//            edge. Directed scenarios add literal expectations, followed by
//            randomized traffic with occasional resets.
// Revision : 1.0  initial release
// ============================================================================
module tb_ula_wb_buffer;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_r1 = '0;
    logic        in_uf = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_we = 1'b0;
    logic        in_cmp = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        flag_q;
    logic [4:0]  fwd_rs = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    ula_wb_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r1     (in_r1),
        .in_uf     (in_uf),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .in_cmp    (in_cmp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .flag_q    (flag_q),
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        we;
        logic        uf;
        logic        cmp;
    } ent_t;

    ent_t q[$];
    logic mflag = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   go = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs applied before it
    task automatic model_step();
        ent_t e;
        bit   push;
        bit   pop;
        if (rst) begin
            q.delete();
            mflag = 1'b0;
        end else begin
            push = in_valid && (q.size() < DEPTH);
            pop  = out_ready && (q.size() > 0);
            if (pop) begin
                e = q.pop_front();
                if (e.cmp) mflag = e.uf;
            end
            if (push) begin
                e.d   = in_r1;
                e.rd  = in_rd;
                e.we  = in_we && (in_rd != 5'd0);
                e.uf  = in_uf;
                e.cmp = in_cmp;
                q.push_back(e);
            end
        end
    endtask

    task automatic compare_all();
        logic        ehit;
        logic [31:0] edata;
        ehit  = 1'b0;
        edata = '0;
        chk("in_ready", in_ready, q.size() != DEPTH);
        chk("out_valid", out_valid, q.size() != 0);
        chk("flag_q", flag_q, mflag);
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_we", out_we, q[0].we);
        end
        for (int i = 0; i < q.size(); i++) begin
            if (fwd_rs != 5'd0 && q[i].we && q[i].rd == fwd_rs) begin
                ehit  = 1'b1;
                edata = q[i].d;
            end
        end
        chk("fwd_hit", fwd_hit, ehit);
        chk("fwd_data", fwd_data, edata);
    endtask

    always @(negedge clk) begin
        if (go) compare_all();
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic set_in(input logic v, input logic [31:0] r1, input logic [4:0] rd,
                          input logic we, input logic cmp, input logic uf);
        in_valid = v;
        in_r1    = r1;
        in_rd    = rd;
        in_we    = we;
        in_cmp   = cmp;
        in_uf    = uf;
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        q.delete();
        mflag = 1'b0;
    endtask

    initial begin
        // Power-on reset
        tick();
        tick();
        rst = 1'b0;
        go  = 1'b1;
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst flag_q", flag_q, 1'b0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst out_rd", out_rd, 5'd0);
        chk("rst fwd_hit", fwd_hit, 1'b0);

        // Fill and stall
        out_ready = 1'b0;
        set_in(1'b1, 32'h11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h22, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        chk("full in_ready", in_ready, 1'b0);
        set_in(1'b1, 32'h33, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        fwd_rs = 5'd3;
        #1;
        chk("stall fwd3 hit", fwd_hit, 1'b1);
        chk("stall fwd3 data", fwd_data, 32'h11);
        fwd_rs = 5'd5;
        #1;
        chk("ignored fwd5 hit", fwd_hit, 1'b0);
        out_ready = 1'b1;
        chk("drain head0", out_data, 32'h11);
        tick();
        #1;
        chk("drain head1", out_data, 32'h22);
        tick();
        #1;
        chk("drained valid", out_valid, 1'b0);

        // Forwarding picks the newest match
        out_ready = 1'b0;
        set_in(1'b1, 32'hA, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'hB, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        fwd_rs = 5'd5;
        #1;
        chk("fwd5 hit", fwd_hit, 1'b1);
        chk("fwd5 data", fwd_data, 32'hB);
        fwd_rs = 5'd6;
        #1;
        chk("fwd6 hit", fwd_hit, 1'b0);
        chk("fwd6 data", fwd_data, 32'h0);
        out_ready = 1'b1;
        tick();
        tick();

        // Flag writeback sequence
        out_ready = 1'b0;
        set_in(1'b1, 32'h1, 5'd1, 1'b1, 1'b1, 1'b1);
        tick();
        set_in(1'b1, 32'h2, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        #1;
        chk("flag after pop1", flag_q, 1'b1);
        set_in(1'b1, 32'h3, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        chk("flag after pop2", flag_q, 1'b1);
        chk("count1 valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();
        #1;
        chk("flag after pop3", flag_q, 1'b0);

        // Register 0 never writes or forwards
        out_ready = 1'b0;
        set_in(1'b1, 32'hFF, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        fwd_rs = 5'd0;
        #1;
        chk("r0 out_we", out_we, 1'b0);
        chk("r0 fwd_hit", fwd_hit, 1'b0);
        out_ready = 1'b1;
        tick();

        // Streaming across pointer wrap: simultaneous push/pop at count 1
        out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            set_in(1'b1, 32'(v), 5'd7, 1'b1, 1'b0, 1'b0);
            tick();
            #1;
            chk("stream data", out_data, 32'(v));
            chk("stream ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        #1;
        chk("stream end valid", out_valid, 1'b0);

        // Reset mid-operation with flag set
        set_in(1'b1, 32'h5, 5'd2, 1'b1, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        set_in(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h55, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("pre-rst flag", flag_q, 1'b1);
        assert_rst();
        #1;
        chk("mid-rst out_valid", out_valid, 1'b0);
        chk("mid-rst in_ready", in_ready, 1'b1);
        chk("mid-rst flag", flag_q, 1'b0);
        tick();
        rst = 1'b0;
        set_in(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("post-rst head", out_data, 32'h77);
        out_ready = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 99) == 0) assert_rst();
            set_in($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
                   $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            fwd_rs    = 5'($urandom_range(0, 7));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
